// File: rtl/cnu_serial.sv
// Serial min-sum check node unit: collects DC variable-to-check messages, then
// emits DC check-to-variable messages in edge order, plus the parity syndrome.
module cnu_serial #(
   parameter int unsigned DC    = 6,
   parameter int unsigned IN_W  = 6,
   parameter int unsigned OUT_W = 5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [IN_W-1:0]             in_msg,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [OUT_W-1:0]            out_msg,
   output logic [$clog2(DC)-1:0]       out_idx,
   output logic                        out_last,
   output logic                        syndrome
);

   localparam int unsigned IDX_W = $clog2(DC);
   localparam int unsigned MAG_W = OUT_W - 1;
   localparam logic [MAG_W-1:0] MAG_MAX  = '1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DC - 1);

   localparam logic [0:0] COLLECT = 1'b0;
   localparam logic [0:0] EMIT    = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [IDX_W-1:0] k_q, j_q, min_idx_q;
   logic [MAG_W-1:0] min1_q, min2_q;
   logic             sgn_all_q;
   logic [DC-1:0]    sign_q;

   logic             accept, emit_hs, in_sign, out_sign;
   logic [IN_W-1:0]  abs_in;
   logic [MAG_W-1:0] mag_in, mag_out;
   logic [OUT_W-1:0] mag_ext;

   // Next-state decode
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      emit_hs = 1'b0;
      case (state_q)
         COLLECT: begin
            accept = in_valid;
            if (in_valid && (k_q == LAST_IDX)) state_d = EMIT;
         end
         EMIT: begin
            emit_hs = out_ready;
            if (out_ready && (j_q == LAST_IDX)) state_d = COLLECT;
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= COLLECT;
      else        state_q <= state_d;
   end

   // Input magnitude, saturated; the most negative input also lands on MAG_MAX
   always_comb begin
      in_sign = in_msg[IN_W-1];
      abs_in  = in_sign ? (~in_msg + IN_W'(1)) : in_msg;
      mag_in  = (abs_in > IN_W'(MAG_MAX)) ? MAG_MAX : abs_in[MAG_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q       <= '0;
         j_q       <= '0;
         min1_q    <= MAG_MAX;
         min2_q    <= MAG_MAX;
         min_idx_q <= '0;
         sgn_all_q <= 1'b0;
         sign_q    <= '0;
         syndrome  <= 1'b0;
      end else begin
         if (accept) begin
            sign_q[k_q] <= in_sign;
            sgn_all_q   <= sgn_all_q ^ in_sign;
            if (mag_in < min1_q) begin
               min2_q    <= min1_q;
               min1_q    <= mag_in;
               min_idx_q <= k_q;
            end else if (mag_in < min2_q) begin
               min2_q <= mag_in;
            end
            if (k_q == LAST_IDX) begin
               k_q      <= '0;
               syndrome <= sgn_all_q ^ in_sign;
            end else begin
               k_q <= k_q + IDX_W'(1);
            end
         end
         // Clearing the accumulators on the final output prepares the next set
         if (emit_hs) begin
            if (j_q == LAST_IDX) begin
               j_q       <= '0;
               min1_q    <= MAG_MAX;
               min2_q    <= MAG_MAX;
               min_idx_q <= '0;
               sgn_all_q <= 1'b0;
               sign_q    <= '0;
            end else begin
               j_q <= j_q + IDX_W'(1);
            end
         end
      end
   end

   // Output decode from registered state only
   always_comb begin
      mag_out  = (j_q == min_idx_q) ? min2_q : min1_q;
      out_sign = sgn_all_q ^ sign_q[j_q];
      mag_ext  = OUT_W'(mag_out);
   end

   assign in_ready  = (state_q == COLLECT);
   assign out_valid = (state_q == EMIT);
   assign out_idx   = (state_q == EMIT) ? j_q : '0;
   assign out_last  = (state_q == EMIT) && (j_q == LAST_IDX);
   assign out_msg   = (state_q != EMIT) ? '0 :
                      out_sign ? (~mag_ext + OUT_W'(1)) : mag_ext;

endmodule

// File: tb/tb_cnu_serial.sv
// Directed bench for cnu_serial with hand-computed min-sum results.
module tb_cnu_serial;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] in_msg;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] out_msg;
   logic [2:0] out_idx;
   logic       out_last;
   logic       syndrome;

   int n_asserts = 0;
   int n_fails   = 0;

   cnu_serial #(.DC(6), .IN_W(6), .OUT_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_msg    (in_msg),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_msg   (out_msg),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .syndrome  (syndrome)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Element i of vec is edge i; called and returns at posedge+1
   task automatic send_set(input logic [35:0] vec);
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_msg   = vec[6*i +: 6];
         check("in_ready_collect", 32'(in_ready), 32'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_msg   = '0;
   endtask

   task automatic recv_set(input logic [29:0] exp, input logic exp_syn, input int stall_idx);
      check("syndrome", 32'(syndrome), 32'(exp_syn));
      out_ready = 1'b1;
      for (int j = 0; j < 6; j++) begin
         if (j == stall_idx) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_msg    = 6'h20;
            for (int s = 0; s < 3; s++) begin
               @(posedge clk); #1;
               check("stall_valid", 32'(out_valid), 32'd1);
               check("stall_idx",   32'(out_idx),   32'(j));
               check("stall_msg",   32'(out_msg),   32'(exp[5*j +: 5]));
               check("stall_ready", 32'(in_ready),  32'd0);
            end
            out_ready = 1'b1;
            in_valid  = 1'b0;
            in_msg    = '0;
         end
         check("out_valid", 32'(out_valid), 32'd1);
         check("out_idx",   32'(out_idx),   32'(j));
         check("out_msg",   32'(out_msg),   32'(exp[5*j +: 5]));
         check("out_last",  32'(out_last),  32'(j == 5));
         check("in_ready_emit", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      check("in_ready_back", 32'(in_ready),  32'd1);
      check("out_valid_off", 32'(out_valid), 32'd0);
      check("syndrome_hold", 32'(syndrome),  32'(exp_syn));
   endtask

   localparam logic [35:0] SET1_IN  = {6'd20, 6'h3E, 6'd10, 6'd7, 6'h3D, 6'd5};
   localparam logic [29:0] SET1_OUT = {5'h02, 5'h1D, 5'h02, 5'h02, 5'h1E, 5'h02};

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_msg    = '0;
      out_ready = 1'b0;
      #12;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_msg",   32'(out_msg),   32'd0);
      check("rst_out_idx",   32'(out_idx),   32'd0);
      check("rst_out_last",  32'(out_last),  32'd0);
      check("rst_syndrome",  32'(syndrome),  32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      send_set(SET1_IN);
      recv_set(SET1_OUT, 1'b0, -1);

      send_set({6{6'h20}});
      recv_set({6{5'h11}}, 1'b0, -1);

      send_set({6'h37, 6'd9, 6'd9, 6'd9, 6'd4, 6'd4});
      recv_set({5'h04, 5'h1C, 5'h1C, 5'h1C, 5'h1C, 5'h1C}, 1'b1, -1);

      send_set('0);
      recv_set('0, 1'b0, -1);
      send_set({6'h3F, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1});
      recv_set({5'h01, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F}, 1'b1, -1);

      send_set(SET1_IN);
      recv_set(SET1_OUT, 1'b0, 2);

      // Partial set of three, then asynchronous reset mid-cycle
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_msg   = 6'd1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready",  32'(in_ready),  32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_idx",   32'(out_idx),   32'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("postrst_out_valid", 32'(out_valid), 32'd0);
      send_set(SET1_IN);
      recv_set(SET1_OUT, 1'b0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule

// File: doc/cnu_serial.md
# cnu_serial

Serial min-sum check node unit for the LDPC decoder. It is the partner of the VNU across the Tanner-graph edge: it takes the 6-bit variable-to-check messages produced by the VNUs, one per cycle, and returns 5-bit check-to-variable messages in the same edge order. The returned messages are the VNU's X inputs. It also reports the parity-check syndrome bit, which the decoder uses for early termination.

## Interface
Parameters:
- DC, 6, row degree: the number of edges per check node, ≥ 2.
- IN_W, 6, width of the incoming VNU message, two's complement.
- OUT_W, 5, width of the outgoing message, two's complement. Magnitude saturates to 2^(OUT_W-1)-1 = 15.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_msg is valid this cycle.
- in_ready  output  1  block accepts an input this cycle.
- in_msg  input  IN_W  variable-to-check message for edge k, sent in order k = 0..DC-1.
- out_valid  output  1  out_msg is valid.
- out_ready  input  1  downstream accepts out_msg.
- out_msg  output  OUT_W  check-to-variable message for edge out_idx.
- out_idx  output  $clog2(DC)  edge index of out_msg.
- out_last  output  1  high with the out_msg for edge DC-1.
- syndrome  output  1  XOR of the sign bits of the last completed input set.

## Operation
- Two states:
  - COLLECT (reset state): in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- COLLECT, on each accepted input (in_valid & in_ready), with edge counter k:
  - sign[k] = in_msg MSB.
  - mag = |in_msg|, saturated to 15. The input -32 maps to 15.
  - Running XOR: sgn_all ^= sign[k].
  - If mag < min1: min2 = min1, min1 = mag, min_idx = k.
  - Else if mag < min2: min2 = mag.
  - min1 and min2 are initialised to 15 at the start of each set.
  - Ties use strict compares: the first occurrence keeps min_idx, and an equal later value lands in min2.
  - k increments. When the accepted input has k = DC-1: k clears, syndrome is loaded with the final sgn_all, and the state moves to EMIT.
- EMIT, for edge j = out_idx:
  - mag_j = (j == min_idx) ? min2 : min1.
  - s_j = sgn_all ^ sign[j].
  - out_msg = s_j ? -mag_j : +mag_j. A zero magnitude always outputs 0, never "negative zero".
  - Each handshake (out_valid & out_ready) advances j. After the handshake with out_last=1, j clears and the state returns to COLLECT.
- in_valid while in EMIT is ignored, because in_ready=0.
- syndrome holds its value until the next set completes.

## Timing
- Reset (asynchronous, rst_n=0): state=COLLECT, k=0, j=0, min1=min2=15, min_idx=0, sgn_all=0, sign[]=0, syndrome=0.
  - Outputs during reset: in_ready=1, out_valid=0, out_msg=0, out_idx=0, out_last=0.
- Reset mid-set, in either state: the partial set is discarded. No output is produced for it.
- Last input accepted at edge t: out_valid=1 from cycle t+1, with out_idx=0. The updated syndrome is visible from t+1.
- No combinational path from any input to any output. in_ready, out_valid, out_msg, out_idx and out_last decode only from registered state.
- Back-pressure: while out_valid=1 and out_ready=0, out_msg, out_idx and out_last hold stable.
- Last output handshake at edge t: in_ready=1 from cycle t+1.
- Minimum period per check node is 2·DC cycles; there is no overlap between COLLECT and EMIT.

## Test plan
- Inputs 5, -3, 7, 10, -2, 20 -> outputs 2, -2, 2, 2, -3, 2 (out_idx 0..5, out_last only at index 5); syndrome=0.
- Six inputs of -32 (6'b100000) -> every out_msg = -15 (5'b10001); syndrome=0. Covers saturation.
- Inputs 4, 4, 9, 9, 9, -9 -> outputs -4, -4, -4, -4, -4, 4; syndrome=1. Covers the tie, where min_idx=0 and min2=4.
- All-zero inputs -> all outputs 0, syndrome=0. Then a back-to-back second set of 1, 1, 1, 1, 1, -1 -> outputs -1×5, then 1; syndrome=1. Checks that in_ready returns one cycle after the first set's out_last handshake.
- First set again, with out_ready held low for 3 cycles at out_idx=2 -> out_msg=2, out_idx=2 held stable; in_ready=0 throughout; the remaining outputs are unchanged.
- Three inputs accepted, then rst_n pulsed low mid-cycle -> in_ready=1 and out_valid=0 immediately; a following first-set stimulus yields exactly the first scenario's outputs.
